// File: rtl/wire_lamp_bank_pkg.sv
// Shared types and helpers for the wire lamp bank.
package wirelog_pkg;

    // Lamp bank request state
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } lamp_fsm_t;

    // Counter width that holds 0..max_toggles inclusive
    function automatic int cnt_width(input int max_toggles);
        return (max_toggles < 1) ? 1 : $clog2(max_toggles + 1);
    endfunction

endpackage

// File: rtl/wire_lamp_bank_if.sv
// Wire pulses in, lamp states and evaluation request out.
interface wire_lamp_bank_if #(
    parameter int LAMP_COUNT = 2
);
    logic                  logic_reset;
    logic [LAMP_COUNT-1:0] toggle_in;
    logic                  fault_toggle;
    logic                  eval_ack;
    logic [LAMP_COUNT-1:0] lamps;
    logic                  fault_lamp;
    logic                  eval_req;
    logic                  overflow;

    modport master (
        output logic_reset, toggle_in, fault_toggle, eval_ack,
        input  lamps, fault_lamp, eval_req, overflow
    );

    modport slave (
        input  logic_reset, toggle_in, fault_toggle, eval_ack,
        output lamps, fault_lamp, eval_req, overflow
    );
endinterface

// File: rtl/wire_lamp_bank_toggle_limiter.sv
// Per-frame toggle budget: saturating event counter plus sticky overflow flag.
module toggle_limiter
    import wirelog_pkg::*;
#(
    parameter int MAX_TOGGLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_event,
    output logic o_accept,
    output logic o_overflow
);
    localparam int             W     = cnt_width(MAX_TOGGLES);
    localparam logic [W-1:0]   MAX_C = W'(MAX_TOGGLES);

    logic [W-1:0] r_count;
    logic         r_overflow;
    logic         w_room;

    assign w_room     = (r_count < MAX_C);
    // A frame restart swallows any event presented in the same cycle
    assign o_accept   = i_event && w_room && !i_clear;
    assign o_overflow = r_overflow;

    // Count accepted events, saturate at the budget and flag drops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_clear) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_event) begin
            if (w_room) begin
                r_count <= r_count + 1'b1;
            end else begin
                r_overflow <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/wire_lamp_bank.sv
// Logic and fault lamps toggled by wire pulses, with req/ack evaluation request.
//
// state | meaning
// IDLE  | lamps settled, no evaluation pending
// REQ   | eval_req high, gate should evaluate current lamps
module wire_lamp_bank
    import wirelog_pkg::*;
#(
    parameter int          LAMP_COUNT  = 2,
    parameter int unsigned INIT_STATE  = 0,
    parameter bit          INIT_FAULT  = 1'b0,
    parameter int          MAX_TOGGLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    wire_lamp_bank_if.slave       bus
);
    localparam logic [LAMP_COUNT-1:0] INIT_L = LAMP_COUNT'(INIT_STATE);

    logic [LAMP_COUNT-1:0] r_lamps;
    logic                  r_fault;
    lamp_fsm_t             r_state;
    lamp_fsm_t             w_state_nxt;
    logic                  w_event;
    logic                  w_accept;
    logic                  w_overflow;
    logic                  w_eval_req;

    // Any pulse counts as one event, even if bits cancel out
    assign w_event = (|bus.toggle_in) | bus.fault_toggle;

    toggle_limiter #(
        .MAX_TOGGLES (MAX_TOGGLES)
    ) u_limiter (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (bus.logic_reset),
        .i_event    (w_event),
        .o_accept   (w_accept),
        .o_overflow (w_overflow)
    );

    // Lamp registers flip only on accepted events
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lamps <= INIT_L;
            r_fault <= INIT_FAULT;
        end else if (bus.logic_reset) begin
            r_lamps <= INIT_L;
            r_fault <= INIT_FAULT;
        end else if (w_accept) begin
            r_lamps <= r_lamps ^ bus.toggle_in;
            r_fault <= r_fault ^ bus.fault_toggle;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; a new event in the ack cycle keeps the request alive
    always_comb begin
        w_state_nxt = r_state;
        if (bus.logic_reset) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_accept) w_state_nxt = REQ;
                REQ:     if (!w_accept && bus.eval_ack) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // FSM outputs decoded straight from the state flop so async reset drops them at once
    always_comb begin
        w_eval_req = (r_state == REQ);
    end

    assign bus.lamps      = r_lamps;
    assign bus.fault_lamp = r_fault;
    assign bus.eval_req   = w_eval_req;
    assign bus.overflow   = w_overflow;
endmodule

// File: tb/tb_wire_lamp_bank.sv
// Directed bench for wire_lamp_bank with an expected-result queue.
module tb_wire_lamp_bank;
    localparam int          LC   = 2;
    localparam int unsigned INIT = 1;
    localparam bit          INF  = 1'b1;
    localparam int          MAXT = 3;

    typedef struct {
        string        tag;
        logic [LC-1:0] lamps;
        logic         fault;
        logic         req;
        logic         ovf;
        int           cnt;
    } exp_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;
    exp_t sb[$];

    logic [LC-1:0] m_lamps;
    logic          m_fault;
    logic          m_req;
    logic          m_ovf;
    int            m_cnt;

    wire_lamp_bank_if #(.LAMP_COUNT(LC)) bus_if ();

    wire_lamp_bank #(
        .LAMP_COUNT  (LC),
        .INIT_STATE  (INIT),
        .INIT_FAULT  (INF),
        .MAX_TOGGLES (MAXT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lamps = LC'(INIT);
        m_fault = INF;
        m_req   = 1'b0;
        m_ovf   = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag; e.lamps = m_lamps; e.fault = m_fault;
        e.req = m_req; e.ovf = m_ovf; e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        check({e.tag, ".lamps"}, 32'(bus_if.lamps), 32'(e.lamps));
        check({e.tag, ".fault"}, 32'(bus_if.fault_lamp), 32'(e.fault));
        check({e.tag, ".req"}, 32'(bus_if.eval_req), 32'(e.req));
        check({e.tag, ".ovf"}, 32'(bus_if.overflow), 32'(e.ovf));
        check({e.tag, ".cnt"}, 32'(dut.u_limiter.r_count), 32'(e.cnt));
    endtask

    // One clock of stimulus: drive at negedge, predict, sample 1ns after posedge
    task automatic step(input string tag, input logic [LC-1:0] tog, input logic ft,
                        input logic ack, input logic lr);
        logic ev;
        logic acc;
        @(negedge clk);
        bus_if.toggle_in    = tog;
        bus_if.fault_toggle = ft;
        bus_if.eval_ack     = ack;
        bus_if.logic_reset  = lr;
        ev = (|tog) | ft;
        if (lr) begin
            model_reset();
        end else begin
            acc = ev && (m_cnt < MAXT);
            if (acc) begin
                m_lamps = m_lamps ^ tog;
                m_fault = m_fault ^ ft;
                m_cnt++;
                m_req = 1'b1;
            end else begin
                if (ev) m_ovf = 1'b1;
                if (ack) m_req = 1'b0;
            end
        end
        push_exp(tag);
        @(posedge clk);
        #1;
        pop_check();
        bus_if.toggle_in    = '0;
        bus_if.fault_toggle = 1'b0;
        bus_if.eval_ack     = 1'b0;
        bus_if.logic_reset  = 1'b0;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        bus_if.toggle_in    = '0;
        bus_if.fault_toggle = 1'b0;
        bus_if.eval_ack     = 1'b0;
        bus_if.logic_reset  = 1'b0;

        // Reset state visible before any clock edge
        reset = 1'b1;
        model_reset();
        #1;
        push_exp("reset");
        pop_check();
        check("reset.lamps_const", 32'(bus_if.lamps), 32'h1);
        @(negedge clk);
        reset = 1'b0;

        // Single toggle then ack
        step("tog10", 2'b10, 1'b0, 1'b0, 1'b0);
        check("tog10.lamps_const", 32'(bus_if.lamps), 32'h3);
        step("ack1", 2'b00, 1'b0, 1'b1, 1'b0);
        check("ack1.req_const", 32'(bus_if.eval_req), 32'h0);
        step("idle", 2'b00, 1'b0, 1'b0, 1'b0);
        step("ack_idle", 2'b00, 1'b0, 1'b1, 1'b0);

        // Ack collides with a fault toggle: request must not drop
        step("tog01", 2'b01, 1'b0, 1'b0, 1'b0);
        step("collide", 2'b00, 1'b1, 1'b1, 1'b0);
        check("collide.req_const", 32'(bus_if.eval_req), 32'h1);
        check("collide.fault_const", 32'(bus_if.fault_lamp), 32'h0);
        step("ack2", 2'b00, 1'b0, 1'b1, 1'b0);

        // Budget already spent: a drop from IDLE must not request
        step("drop_idle", 2'b01, 1'b0, 1'b0, 1'b0);

        // Fresh frame then saturate
        step("lr1", 2'b00, 1'b0, 1'b0, 1'b1);
        step("sat1", 2'b01, 1'b0, 1'b0, 1'b0);
        step("sat2", 2'b01, 1'b0, 1'b0, 1'b0);
        step("sat3", 2'b01, 1'b0, 1'b0, 1'b0);
        step("sat4", 2'b01, 1'b0, 1'b0, 1'b0);
        check("sat4.lamps_const", 32'(bus_if.lamps), 32'h0);
        check("sat4.ovf_const", 32'(bus_if.overflow), 32'h1);

        // Frame restart beats a simultaneous toggle
        step("lr_tog", 2'b11, 1'b0, 1'b0, 1'b1);
        check("lr_tog.lamps_const", 32'(bus_if.lamps), 32'h1);
        step("post_lr", 2'b10, 1'b0, 1'b0, 1'b0);
        step("cancel", 2'b00, 1'b0, 1'b1, 1'b0);
        step("net_zero", 2'b11, 1'b1, 1'b0, 1'b0);

        // Async reset between edges drops the request immediately
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        push_exp("async_rst");
        pop_check();
        check("async_rst.req_const", 32'(bus_if.eval_req), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step("ack_after_rst", 2'b00, 1'b0, 1'b1, 1'b0);

        // A few pseudo-random pulses within a frame
        for (int i = 0; i < 8; i++) begin
            step("rand", LC'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
